// File: rtl/mod_arith_pkg.sv
// -----------------------------------------------------------------------------
// mod_arith_pkg
//   Shared definitions for the residue-channel modular adder.
//   - Default residue width, modulus (3^11) and error-counter width.
//   - residue_t: one residue word at the default channel width.
//   - skid_state_e: occupancy of the output-register + skid-entry pair.
//   No ports (package).
// -----------------------------------------------------------------------------
package mod_arith_pkg;

  // Residue channel geometry
  localparam int unsigned RES_WIDTH     = 18;
  localparam int unsigned RES_MODULUS   = 177147;  // 3^11, below 2^RES_WIDTH
  localparam int unsigned ERR_CNT_WIDTH = 16;

  typedef logic [RES_WIDTH-1:0] residue_t;

  // EMPTY: output register empty; ONE: output register full, skid empty;
  // TWO: both full (upstream is stalled).
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage : mod_arith_pkg

// File: rtl/mod_skid_buf.sv
// -----------------------------------------------------------------------------
// mod_skid_buf
//   Generic 2-entry valid/ready skid buffer: one output register (OR) plus one
//   skid entry (SK). in_ready is registered and only drops once SK holds a
//   word, so a word offered while the output is stalled is always caught.
//   Ports:
//     clk, reset           rising-edge clock, synchronous active-high reset
//     in_valid / in_ready  upstream handshake (in_ready registered)
//     in_data              word offered upstream
//     out_valid/out_ready  downstream handshake (out_valid registered)
//     out_data             head word, held stable while stalled
// -----------------------------------------------------------------------------
module mod_skid_buf
  import mod_arith_pkg::*;
#(
  parameter int unsigned WIDTH = RES_WIDTH + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] or_data_q, or_data_d;
  logic [WIDTH-1:0] sk_data_q, sk_data_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             accept_s;
  logic             xfer_s;

  // Next-state, data-movement and next-output computation for the buffer.
  always_comb begin
    accept_s  = in_valid & in_ready_q;
    xfer_s    = out_valid_q & out_ready;
    state_d   = state_q;
    or_data_d = or_data_q;
    sk_data_d = sk_data_q;

    case (state_q)
      SKID_EMPTY: begin
        // Nothing to transfer here, out_valid is low.
        if (accept_s) begin
          state_d   = SKID_ONE;
          or_data_d = in_data;
        end else begin
          state_d   = SKID_EMPTY;
        end
      end
      SKID_ONE: begin
        if (accept_s && xfer_s) begin
          state_d   = SKID_ONE;
          or_data_d = in_data;
        end else if (accept_s) begin
          // Output stalled: park the new word in the skid entry.
          state_d   = SKID_TWO;
          sk_data_d = in_data;
        end else if (xfer_s) begin
          state_d   = SKID_EMPTY;
        end else begin
          state_d   = SKID_ONE;
        end
      end
      SKID_TWO: begin
        // in_ready is low here, so only the drain path exists.
        if (xfer_s) begin
          state_d   = SKID_ONE;
          or_data_d = sk_data_q;
        end else begin
          state_d   = SKID_TWO;
        end
      end
      default: begin
        state_d   = SKID_EMPTY;
      end
    endcase

    out_valid_d = (state_d != SKID_EMPTY);
    in_ready_d  = (state_d != SKID_TWO);
  end

  // Buffer state, data registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SKID_EMPTY;
      or_data_q   <= {WIDTH{1'b0}};
      sk_data_q   <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      or_data_q   <= or_data_d;
      sk_data_q   <= sk_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = or_data_q;

endmodule : mod_skid_buf

// File: rtl/mod_add_select_stage.sv
// -----------------------------------------------------------------------------
// mod_add_select_stage
//   Second stage of the 2x2 modular adder. Stage 1 supplies both candidates:
//   cand_a = A+CONST and cand_b = A+CONST-MODULUS with the sign of the
//   subtraction. This stage picks the in-range residue, flags any selected
//   value >= MODULUS, buffers the result through a skid buffer and keeps a
//   saturating count of errored words that leave the stage.
//   Ports:
//     clk, reset           rising-edge clock, synchronous active-high reset
//     in_valid / in_ready  upstream handshake
//     cand_a, cand_b       stage-1 candidates
//     sign_in              1 = cand_b negative, select cand_a
//     out_valid/out_ready  downstream handshake
//     result, range_err    selected residue and its out-of-range flag
//     clr_count            synchronous clear of err_count
//     err_count            saturating count of errored output transfers
// -----------------------------------------------------------------------------
module mod_add_select_stage
  import mod_arith_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RES_WIDTH,
  parameter int unsigned MODULUS    = RES_MODULUS,
  parameter int unsigned CNT_WIDTH  = ERR_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] cand_a,
  input  logic [DATA_WIDTH-1:0] cand_b,
  input  logic                  sign_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  range_err,
  input  logic                  clr_count,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam logic [DATA_WIDTH-1:0] MOD_V    = DATA_WIDTH'(MODULUS);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = {CNT_WIDTH{1'b0}};

  logic                  accept_s;
  logic [DATA_WIDTH-1:0] sel_s;
  logic                  err_s;
  logic [DATA_WIDTH:0]   buf_in_s;
  logic [DATA_WIDTH:0]   buf_out_s;
  logic                  err_xfer_s;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  // Candidate select and range compare. The word fed to the buffer is forced
  // to zero unless it is being accepted, so unknown inputs on idle cycles
  // never reach the data path.
  always_comb begin
    accept_s = in_valid & in_ready;
    if (sign_in) begin
      sel_s = cand_a;
    end else begin
      sel_s = cand_b;
    end
    err_s = (sel_s >= MOD_V);
    if (accept_s) begin
      buf_in_s = {err_s, sel_s};
    end else begin
      buf_in_s = {(DATA_WIDTH + 1){1'b0}};
    end
  end

  mod_skid_buf #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (buf_in_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out_s)
  );

  assign result    = buf_out_s[DATA_WIDTH-1:0];
  assign range_err = buf_out_s[DATA_WIDTH];

  // Error counter next value: a clear wins over the old count, but an errored
  // transfer in the same cycle still counts as one.
  always_comb begin
    err_xfer_s = out_valid & out_ready & range_err;
    cnt_d      = cnt_q;
    if (clr_count) begin
      if (err_xfer_s) begin
        cnt_d = CNT_ONE;
      end else begin
        cnt_d = CNT_ZERO;
      end
    end else if (err_xfer_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_count = cnt_q;

endmodule : mod_add_select_stage

// File: tb/tb_mod_add_select_stage.sv
module tb_mod_add_select_stage;
  import mod_arith_pkg::*;

  localparam int M  = 177147;
  localparam int NW = 10000;

  logic        clk = 1'b0;
  logic        reset, in_valid, sign_in, out_ready, clr_count;
  residue_t    cand_a, cand_b;
  logic        in_ready, out_valid, range_err;
  residue_t    result;
  logic [15:0] err_count;
  logic        in_ready2, out_valid2, range_err2;
  residue_t    result2;
  logic [1:0]  err_count2;

  always #5 clk = ~clk;

  mod_add_select_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .cand_a(cand_a), .cand_b(cand_b), .sign_in(sign_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .range_err(range_err), .clr_count(clr_count), .err_count(err_count)
  );

  mod_add_select_stage #(.CNT_WIDTH(2)) dut_c2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .cand_a(cand_a), .cand_b(cand_b), .sign_in(sign_in),
    .out_valid(out_valid2), .out_ready(out_ready), .result(result2),
    .range_err(range_err2), .clr_count(clr_count), .err_count(err_count2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a FIFO of at most two words ----------
  int  q_res[$];
  bit  q_err[$];
  int  q_gold[$];
  bit  m_in_ready;
  int  m_cnt16, m_cnt2;
  bit  live = 1'b0;
  bit  rand_mode = 1'b0;
  int  cur_a, cur_c;
  bit  m_xfer, m_errx, m_acc;
  int  m_sel;

  always @(posedge clk) begin
    if (reset) begin
      q_res.delete(); q_err.delete(); q_gold.delete();
      m_in_ready = 1'b0;
      m_cnt16 = 0;
      m_cnt2  = 0;
      live    = 1'b1;
    end else if (live) begin
      m_xfer = (q_res.size() > 0) && out_ready;
      m_errx = m_xfer && q_err[0];
      m_acc  = in_valid && m_in_ready;
      if (m_xfer) begin
        void'(q_res.pop_front()); void'(q_err.pop_front()); void'(q_gold.pop_front());
      end
      if (m_acc) begin
        m_sel = sign_in ? int'(cand_a) : int'(cand_b);
        q_res.push_back(m_sel);
        q_err.push_back(m_sel >= M);
        q_gold.push_back(rand_mode ? (cur_a + cur_c) % M : -1);
      end
      m_in_ready = (q_res.size() < 2);
      if (clr_count) begin
        m_cnt16 = m_errx ? 1 : 0;
        m_cnt2  = m_errx ? 1 : 0;
      end else if (m_errx) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  end

  // ---------------- compare process ------------------------------------------
  always @(negedge clk) begin
    if (live) begin
      chk("in_ready", in_ready, m_in_ready);
      chk("out_valid", out_valid, q_res.size() > 0);
      chk("out_valid_c2", out_valid2, q_res.size() > 0);
      chk("err_count", err_count, m_cnt16);
      chk("err_count_c2", err_count2, m_cnt2);
      if (q_res.size() > 0) begin
        chk("result", result, q_res[0]);
        chk("range_err", range_err, q_err[0]);
        chk("result_c2", result2, q_res[0]);
        if (q_gold[0] >= 0) chk("mod_sum", result, q_gold[0]);
      end
    end
  end

  task automatic put(input bit v, input bit s, input int a, input int b);
    in_valid = v;
    sign_in  = s;
    cand_a   = residue_t'(a);
    cand_b   = residue_t'(b);
  endtask

  int  sent, cyc, s;
  bit  took;

  initial begin
    reset = 1'b1; clr_count = 1'b0; out_ready = 1'b0;
    put(1'b0, 1'b0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_range_err", range_err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // 1: negative cand_b -> cand_a
    out_ready = 1'b1;
    put(1'b1, 1'b1, 5, 'h3AC7E);
    @(negedge clk);
    chk("t1_valid", out_valid, 1);
    chk("t1_result", result, 5);
    chk("t1_err", range_err, 0);

    // 2: cand_b selected, then an out-of-range cand_a
    put(1'b1, 1'b0, 177150, 3);
    @(negedge clk);
    chk("t2_result", result, 3);
    chk("t2_err", range_err, 0);
    put(1'b1, 1'b1, 177147, 7);
    @(negedge clk);
    chk("t2b_result", result, 177147);
    chk("t2b_err", range_err, 1);
    put(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    chk("t2_count", err_count, 1);
    chk("t2_count_c2", err_count2, 1);

    // 3: stream 0..3 with a downstream stall
    out_ready = 1'b0;
    put(1'b1, 1'b1, 0, 'h3FFFF);
    @(negedge clk);
    chk("t3_ready_one", in_ready, 1);
    put(1'b1, 1'b1, 1, 'h3FFFF);
    @(negedge clk);
    chk("t3_ready_full", in_ready, 0);
    chk("t3_head0", result, 0);
    put(1'b1, 1'b1, 2, 'h3FFFF);
    @(negedge clk);
    chk("t3_hold0", result, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_head1", result, 1);
    chk("t3_ready_back", in_ready, 1);
    @(negedge clk);
    chk("t3_head2", result, 2);
    put(1'b1, 1'b1, 3, 'h3FFFF);
    @(negedge clk);
    chk("t3_head3", result, 3);
    put(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    chk("t3_drained", out_valid, 0);

    // 4: saturation and clear/increment collision
    clr_count = 1'b1;
    @(negedge clk);
    chk("t4_clr", err_count, 0);
    chk("t4_clr_c2", err_count2, 0);
    clr_count = 1'b0;
    put(1'b1, 1'b1, 200000, 0);
    repeat (4) @(negedge clk);
    put(1'b0, 1'b0, 0, 0);
    repeat (2) @(negedge clk);
    chk("t4_count4", err_count, 4);
    chk("t4_sat_c2", err_count2, 3);
    put(1'b1, 1'b1, 200000, 0);
    @(negedge clk);
    put(1'b0, 1'b0, 0, 0);
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    chk("t4_clr_inc", err_count, 1);
    chk("t4_clr_inc_c2", err_count2, 1);

    // 5: reset with both entries full
    out_ready = 1'b0;
    put(1'b1, 1'b1, 10, 0);
    @(negedge clk);
    put(1'b1, 1'b1, 11, 0);
    @(negedge clk);
    put(1'b0, 1'b0, 0, 0);
    chk("t5_full_ready", in_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_valid", out_valid, 0);
    chk("t5_count", err_count, 0);
    chk("t5_ready", in_ready, 0);
    chk("t5_result", result, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_ready_after", in_ready, 1);
    @(negedge clk);
    chk("t5_no_partial", out_valid, 0);

    // 6: random valid/ready against (A+CONST) mod MODULUS
    void'($urandom(32'd2024));
    rand_mode = 1'b1;
    sent = 0; cyc = 0;
    cur_a = $urandom_range(0, M - 1);
    cur_c = $urandom_range(0, M - 1);
    while (sent < NW && cyc < 80000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) begin
        s = cur_a + cur_c;
        put(1'b1, s < M, s, s - M);
      end else begin
        put(1'b0, $urandom_range(0, 1) == 1, $urandom, $urandom);
      end
      took = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (took) begin
        sent++;
        cur_a = $urandom_range(0, M - 1);
        cur_c = $urandom_range(0, M - 1);
      end
    end
    put(1'b0, 1'b0, 0, 0);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    rand_mode = 1'b0;
    chk("t6_sent", sent, NW);
    chk("t6_drained", out_valid, 0);
    chk("t6_no_errors", err_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mod_add_select_stage
